// File: rtl/rob_commit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_if
//  Description : Bundle of the allocation, common-data-bus and retirement
//                signals between the issue stage / execution units and the
//                reorder buffer.
//                master : issue stage + CDB side (drives alloc_* and cdb_*)
//                slave  : reorder buffer (drives alloc handshake replies,
//                         commit_*, rf_we, mem_we, flush, count)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rob_commit_if #(
    parameter int IDX_W  = 3,
    parameter int DATA_W = 8
);
    // Allocation from issue
    logic              alloc_valid;
    logic [3:0]        alloc_func;
    logic [3:0]        alloc_rd;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_idx;
    // Common data bus
    logic              cdb_valid;
    logic [IDX_W-1:0]  cdb_idx;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_taken;
    // Retirement
    logic              commit_valid;
    logic [IDX_W-1:0]  commit_idx;
    logic [3:0]        commit_func;
    logic [3:0]        commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic              rf_we;
    logic              mem_we;
    logic              flush;
    logic [IDX_W:0]    count;

    modport master (
        output alloc_valid, alloc_func, alloc_rd,
        output cdb_valid, cdb_idx, cdb_data, cdb_taken,
        input  alloc_ready, alloc_idx,
        input  commit_valid, commit_idx, commit_func, commit_rd, commit_data,
        input  rf_we, mem_we, flush, count
    );

    modport slave (
        input  alloc_valid, alloc_func, alloc_rd,
        input  cdb_valid, cdb_idx, cdb_data, cdb_taken,
        output alloc_ready, alloc_idx,
        output commit_valid, commit_idx, commit_func, commit_rd, commit_data,
        output rf_we, mem_we, flush, count
    );
endinterface
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit
//  Description : Reorder buffer with strict in-order retirement. Entries are
//                allocated at the tail in program order, filled out of order
//                from the common data bus, and retired one per cycle from the
//                head, producing registered regbank / memory write strobes.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk1   in  clock, all state updates on the rising edge
//    rst_n  in  synchronous active-low reset
//    rob    rob_commit_if.slave : alloc_*, cdb_*, commit_*, rf_we, mem_we,
//                                 flush, count
//
//  Configuration macro
//    ROB_BRANCH_FLUSH_EN : when defined, retiring a taken branch empties the
//                          buffer and pulses flush for one cycle. When
//                          undefined, branches retire as no-ops and flush is 0.
// ============================================================================
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 8
) (
    input  wire logic       clk1,
    input  wire logic       rst_n,
    rob_commit_if.slave     rob
);

    localparam logic [IDX_W:0] c_DEPTH   = (IDX_W+1)'(DEPTH);
    localparam logic [3:0]     c_F_LOAD  = 4'b0100;
    localparam logic [3:0]     c_F_STORE = 4'b0101;
    localparam logic [3:0]     c_F_BEQ   = 4'b0110;
    localparam logic [3:0]     c_F_BNEQ  = 4'b0111;

    // Per-entry state
    logic              r_busy  [DEPTH];
    logic              r_ready [DEPTH];
    logic [3:0]        r_func  [DEPTH];
    logic [3:0]        r_rd    [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    logic              r_taken [DEPTH];

    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [IDX_W:0]    r_count;

    // Registered retirement outputs
    logic              r_commit_valid;
    logic [IDX_W-1:0]  r_commit_idx;
    logic [3:0]        r_commit_func;
    logic [3:0]        r_commit_rd;
    logic [DATA_W-1:0] r_commit_data;
    logic              r_rf_we;
    logic              r_mem_we;

    logic              w_flush;
    logic              w_alloc_ready;
    logic              w_alloc;
    logic              w_retire;
    logic              w_cdb_hit;
    logic              w_head_branch;

    // No bypass: a full buffer refuses allocation even when the head retires
    // in the same cycle.
    assign w_alloc_ready = (r_count < c_DEPTH) && !w_flush;
    assign w_alloc       = rob.alloc_valid && w_alloc_ready;
    // An empty buffer has no busy head, so this never fires when empty.
    assign w_retire      = r_busy[r_head] && r_ready[r_head];
    // Only busy entries accept results; this also drops a result aimed at the
    // index being allocated this cycle, since that entry is not yet busy.
    assign w_cdb_hit     = rob.cdb_valid && r_busy[rob.cdb_idx];
    assign w_head_branch = (r_func[r_head] == c_F_BEQ) || (r_func[r_head] == c_F_BNEQ);

`ifdef ROB_BRANCH_FLUSH_EN
    logic r_flush;
    logic w_flush_take;

    assign w_flush_take = w_retire && w_head_branch && r_taken[r_head];
    assign w_flush      = r_flush;
`else
    // Branch outcome is captured but has no architectural effect here.
    logic w_unused_branch;

    assign w_unused_branch = w_head_branch ^ r_taken[r_head];
    assign w_flush         = 1'b0;
`endif

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_idx   <= '0;
            r_commit_func  <= '0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
            r_rf_we        <= 1'b0;
            r_mem_we       <= 1'b0;
`ifdef ROB_BRANCH_FLUSH_EN
            r_flush        <= 1'b0;
`endif
        end else begin
            if (w_cdb_hit) begin
                r_ready[rob.cdb_idx] <= 1'b1;
                r_data[rob.cdb_idx]  <= rob.cdb_data;
                r_taken[rob.cdb_idx] <= rob.cdb_taken;
            end

            // Commit fields come from the pre-edge head contents; a CDB write
            // landing on the retiring head is overridden by the clear below.
            if (w_retire) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
                r_commit_valid  <= 1'b1;
                r_commit_idx    <= r_head;
                r_commit_func   <= r_func[r_head];
                r_commit_rd     <= r_rd[r_head];
                r_commit_data   <= r_data[r_head];
                r_rf_we         <= (r_func[r_head] <= c_F_LOAD);
                r_mem_we        <= (r_func[r_head] == c_F_STORE);
            end else begin
                r_commit_valid  <= 1'b0;
                r_rf_we         <= 1'b0;
                r_mem_we        <= 1'b0;
            end

            if (w_alloc) begin
                r_func[r_tail]  <= rob.alloc_func;
                r_rd[r_tail]    <= rob.alloc_rd;
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end

            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

`ifdef ROB_BRANCH_FLUSH_EN
            r_flush <= w_flush_take;
            // Taken branch: squash every younger entry, including one being
            // allocated on this same edge (last assignment wins).
            if (w_flush_take) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_busy[i]  <= 1'b0;
                    r_ready[i] <= 1'b0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end
`endif
        end
    end

    assign rob.alloc_ready  = w_alloc_ready;
    assign rob.alloc_idx    = r_tail;
    assign rob.count        = r_count;
    assign rob.commit_valid = r_commit_valid;
    assign rob.commit_idx   = r_commit_idx;
    assign rob.commit_func  = r_commit_func;
    assign rob.commit_rd    = r_commit_rd;
    assign rob.commit_data  = r_commit_data;
    assign rob.rf_we        = r_rf_we;
    assign rob.mem_we       = r_mem_we;
    assign rob.flush        = w_flush;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_commit
//  Description : Self-checking bench for rob_commit. A queue-based program-
//                order model predicts every output each cycle; directed
//                scenarios are followed by a randomized stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_commit;

    logic clk1 = 1'b0;
    logic rst_n;
    always #5 clk1 = ~clk1;

    rob_commit_if #(.IDX_W(3), .DATA_W(8)) bus ();

    rob_commit #(.DEPTH(8), .IDX_W(3), .DATA_W(8)) dut (
        .clk1 (clk1),
        .rst_n(rst_n),
        .rob  (bus.slave)
    );

    typedef struct {
        logic [2:0] idx;
        logic [3:0] func;
        logic [3:0] rd;
        bit         rdy;
        logic [7:0] data;
        bit         taken;
    } ent_t;

    ent_t       q[$];
    logic [2:0] m_tail;
    bit         m_flush;
    bit         e_cv, e_rf, e_mem;
    logic [2:0] e_idx;
    logic [3:0] e_func, e_rd;
    logic [7:0] e_data;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: check combinational outputs, advance the model, let the
    // edge happen, then check registered outputs.
    task automatic step();
        bit   acc, ret, fl;
        ent_t e;
        #1;
        chk("alloc_ready", bus.alloc_ready, (q.size() < 8) && !m_flush);
        chk("alloc_idx",   bus.alloc_idx,   m_tail);
        chk("count",       bus.count,       q.size());

        if (!rst_n) begin
            q.delete();
            m_tail = 0; m_flush = 0;
            e_cv = 0; e_rf = 0; e_mem = 0;
            e_idx = 0; e_func = 0; e_rd = 0; e_data = 0;
        end else begin
            acc = bus.alloc_valid && (q.size() < 8) && !m_flush;
            ret = (q.size() > 0) && q[0].rdy;
            fl  = 0;
            if (ret) begin
                e      = q.pop_front();
                e_cv   = 1;
                e_idx  = e.idx; e_func = e.func; e_rd = e.rd; e_data = e.data;
                e_rf   = (e.func <= 4);
                e_mem  = (e.func == 5);
`ifdef ROB_BRANCH_FLUSH_EN
                fl = (e.func == 6 || e.func == 7) && e.taken;
`endif
            end else begin
                e_cv = 0; e_rf = 0; e_mem = 0;
            end
            if (bus.cdb_valid)
                foreach (q[i])
                    if (q[i].idx == bus.cdb_idx) begin
                        q[i].rdy   = 1;
                        q[i].data  = bus.cdb_data;
                        q[i].taken = bus.cdb_taken;
                    end
            if (fl) begin
                q.delete();
                m_tail = 0;
            end else if (acc) begin
                q.push_back('{idx: m_tail, func: bus.alloc_func, rd: bus.alloc_rd,
                              rdy: 0, data: 8'h00, taken: 0});
                m_tail = m_tail + 3'd1;
            end
            m_flush = fl;
        end

        @(posedge clk1);
        #1;
        chk("commit_valid", bus.commit_valid, e_cv);
        chk("rf_we",        bus.rf_we,        e_rf);
        chk("mem_we",       bus.mem_we,       e_mem);
        chk("flush",        bus.flush,        m_flush);
        if (e_cv || !rst_n) begin
            chk("commit_idx",  bus.commit_idx,  e_idx);
            chk("commit_func", bus.commit_func, e_func);
            chk("commit_rd",   bus.commit_rd,   e_rd);
            chk("commit_data", bus.commit_data, e_data);
        end
    endtask

    task automatic drv(bit av, logic [3:0] f, logic [3:0] rd,
                       bit cv, logic [2:0] ci, logic [7:0] cd, bit ct);
        bus.alloc_valid = av;
        bus.alloc_func  = f;
        bus.alloc_rd    = rd;
        bus.cdb_valid   = cv;
        bus.cdb_idx     = ci;
        bus.cdb_data    = cd;
        bus.cdb_taken   = ct;
        step();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drv(0, 4'h0, 4'h0, 0, 3'd0, 8'h00, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle(2);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        bus.alloc_valid = 0; bus.alloc_func = 0; bus.alloc_rd = 0;
        bus.cdb_valid = 0; bus.cdb_idx = 0; bus.cdb_data = 0; bus.cdb_taken = 0;
        q.delete(); m_tail = 0; m_flush = 0;
        e_cv = 0; e_rf = 0; e_mem = 0; e_idx = 0; e_func = 0; e_rd = 0; e_data = 0;
        @(posedge clk1);
        #1;
        do_reset();

        // Single add: commit visible exactly three cycles after allocation
        drv(1, 4'b0000, 4'd3, 0, 3'd0, 8'h00, 0);
        drv(0, 4'h0,    4'd0, 1, 3'd0, 8'h2A, 0);
        idle(1);
        chk("lat3_valid", bus.commit_valid, 1);
        chk("lat3_data",  bus.commit_data,  8'h2A);
        chk("lat3_rd",    bus.commit_rd,    4'd3);
        idle(2);

        // Out-of-order completion, in-order commit
        do_reset();
        drv(1, 4'b0001, 4'd1, 0, 3'd0, 8'h00, 0);
        drv(1, 4'b0010, 4'd2, 0, 3'd0, 8'h00, 0);
        drv(1, 4'b0011, 4'd4, 0, 3'd0, 8'h00, 0);
        drv(0, 4'h0, 4'd0, 1, 3'd2, 8'hC2, 0);
        drv(0, 4'h0, 4'd0, 1, 3'd1, 8'hB1, 0);
        drv(0, 4'h0, 4'd0, 1, 3'd0, 8'hA0, 0);
        idle(4);

        // Full buffer, no bypass on a retiring cycle, tail wrap
        do_reset();
        for (int i = 0; i < 8; i++) drv(1, 4'b0000, 4'(i), 0, 3'd0, 8'h00, 0);
        chk("full_count", bus.count,       8);
        chk("full_ready", bus.alloc_ready, 0);
        drv(1, 4'b0100, 4'd9, 1, 3'd0, 8'h55, 0);
        drv(1, 4'b0100, 4'd9, 0, 3'd0, 8'h00, 0);
        drv(1, 4'b0100, 4'd9, 0, 3'd0, 8'h00, 0);
        idle(2);

        // Store and branch strobes
        do_reset();
        drv(1, 4'b0101, 4'd5, 0, 3'd0, 8'h00, 0);
        drv(1, 4'b0110, 4'd7, 1, 3'd0, 8'h11, 0);
        drv(1, 4'b1010, 4'd8, 1, 3'd1, 8'h22, 0);
        drv(0, 4'h0,    4'd0, 1, 3'd2, 8'h33, 0);
        idle(4);

        // Taken branch with ready younger entries
        do_reset();
        drv(1, 4'b0000, 4'd1, 0, 3'd0, 8'h00, 0);
        drv(1, 4'b0110, 4'd2, 0, 3'd0, 8'h00, 0);
        drv(1, 4'b0000, 4'd3, 0, 3'd0, 8'h00, 0);
        drv(1, 4'b0001, 4'd4, 0, 3'd0, 8'h00, 0);
        drv(0, 4'h0, 4'd0, 1, 3'd3, 8'h03, 0);
        drv(0, 4'h0, 4'd0, 1, 3'd2, 8'h02, 0);
        drv(0, 4'h0, 4'd0, 1, 3'd1, 8'h01, 1);
        drv(0, 4'h0, 4'd0, 1, 3'd0, 8'h00, 0);
        idle(7);
        chk("br_count", bus.count, 0);
`ifdef ROB_BRANCH_FLUSH_EN
        chk("br_alloc_idx", bus.alloc_idx, 3'd0);
`else
        chk("br_alloc_idx", bus.alloc_idx, 3'd4);
`endif

        // Randomized stream with occasional resets
        for (int c = 0; c < 800; c++) begin
            logic [2:0] ci;
            rst_n = ($urandom_range(0, 99) != 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                ci = q[$urandom_range(0, q.size() - 1)].idx;
            else
                ci = 3'($urandom_range(0, 7));
            drv($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom_range(0, 1) != 0, ci,
                8'($urandom), $urandom_range(0, 1) != 0);
        end

        // Mid-stream reset with in-flight entries
        rst_n = 1;
        drv(1, 4'b0000, 4'd6, 0, 3'd0, 8'h00, 0);
        drv(1, 4'b0000, 4'd7, 0, 3'd0, 8'h00, 0);
        do_reset();
        chk("rst_count", bus.count,        0);
        chk("rst_valid", bus.commit_valid, 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
